// File: rtl/full_adder_checker.sv
// Purpose: response checker for a 1-bit full adder driven through all 8 {A,B,Cin} vectors.
// Latency: a vector is compared on its SETTLE-th consecutive stable edge; results show one cycle later.
// Backpressure: none; the stimulus is observed passively and start is ignored while a run is active.
module full_adder_checker #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             A,
    input  logic             B,
    input  logic             Cin,
    input  logic             S,
    input  logic             Cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [7:0]       cov,
    output logic [ERR_W-1:0] err_cnt,
    output logic             first_err_valid,
    output logic [2:0]       first_err_vec
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // settle_cnt holds (edges this vector has been seen) - 1, so the compare
    // fires when it reaches SETTLE-1; the entry edge itself is the first one.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_n;
    logic [2:0]       vec, vec_q, vec_q_n;
    logic [3:0]       settle_cnt, settle_n, cnt_now;
    logic [7:0]       cov_n;
    logic [ERR_W-1:0] err_n;
    logic             fev_n;
    logic [2:0]       fevec_n;
    logic             exp_s, exp_cout;
    logic             launch, active, fresh;

    assign vec      = {A, B, Cin};
    assign exp_s    = A ^ B ^ Cin;
    assign exp_cout = (A & B) | (A & Cin) | (B & Cin);

    // Next-state: launch/restart, settle tracking, compare and coverage update.
    always_comb begin
        state_n  = state;
        vec_q_n  = vec_q;
        settle_n = settle_cnt;
        cov_n    = cov;
        err_n    = err_cnt;
        fev_n    = first_err_valid;
        fevec_n  = first_err_vec;

        launch  = ((state == IDLE) || (state == DONE)) && start;
        active  = launch || (state == WAIT) || ((state == HOLD) && (vec != vec_q));
        // Anything other than a stable edge in WAIT starts a new appearance.
        fresh   = (state != WAIT) || (vec != vec_q);
        cnt_now = fresh ? 4'd0 : (settle_cnt + 4'd1);

        if (launch) begin
            cov_n   = 8'h00;
            err_n   = '0;
            fev_n   = 1'b0;
            fevec_n = 3'b000;
        end

        if (active) begin
            vec_q_n  = vec;
            settle_n = cnt_now;
            state_n  = WAIT;
            if (cnt_now == SETTLE_LAST) begin
                cov_n[vec] = 1'b1;
                if ({S, Cout} != {exp_s, exp_cout}) begin
                    if (err_n != ERR_MAX) begin
                        err_n = err_n + ERR_W'(1);
                    end
                    if (!fev_n) begin
                        fev_n   = 1'b1;
                        fevec_n = vec;
                    end
                end
                state_n = (cov_n == 8'hFF) ? DONE : HOLD;
            end
        end
    end

    // State and registered outputs; reset wins over start and any pending check.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            vec_q           <= 3'b000;
            settle_cnt      <= 4'd0;
            cov             <= 8'h00;
            err_cnt         <= '0;
            first_err_valid <= 1'b0;
            first_err_vec   <= 3'b000;
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
        end else begin
            state           <= state_n;
            vec_q           <= vec_q_n;
            settle_cnt      <= settle_n;
            cov             <= cov_n;
            err_cnt         <= err_n;
            first_err_valid <= fev_n;
            first_err_vec   <= fevec_n;
            busy            <= (state_n == WAIT) || (state_n == HOLD);
            done            <= (state_n == DONE);
            pass            <= (state_n == DONE) && (err_n == '0);
        end
    end

endmodule
